// File: rtl/control_unit_if.sv
// Instruction/memory-status inputs and datapath control strobes of the control unit.
`timescale 1ns/1ps
interface control_unit_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  opcode;
    logic        Run;

    modport slave (
        input  IR, Mem_ready,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
    );

    modport master (
        output IR, Mem_ready,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, opcode, Run
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch (T0-T2), register/ALU execute (T3-T6), HALT.
`timescale 1ns/1ps
module control_unit (
    input  logic           Clock,
    input  logic           clear,
    control_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        RESET_S, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t     state_q, state_d;
    logic       wait_q, wait_d;
    logic [4:0] op;
    logic       is_alu, is_md, is_halt;
    logic       unused_ir;

    assign op        = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_comb begin
        is_alu  = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000};
        is_md   = op inside {5'b01111, 5'b10000};
        is_halt = (op == 5'b11011);
    end

    // wait_q marks a T1 cycle that follows another T1 cycle (memory wait)
    assign wait_d = (state_q == T1);

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= RESET_S;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.PCout    = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.opcode   = '0;
        bus.Run      = !(state_q inside {RESET_S, HALT});

        case (state_q)
            RESET_S: state_d = T0;
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.opcode = 5'b00011;
                state_d    = T1;
            end
            T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                // PC update is a one-shot; wait cycles only keep the MDR loading
                if (!wait_q) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                end
                if (bus.Mem_ready) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                if (is_alu || is_md) begin
                    bus.Grb  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Yin  = 1'b1;
                    state_d  = T4;
                end else if (is_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = T0;
                end
            end
            T4: begin
                bus.Grc    = 1'b1;
                bus.Rout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.opcode = op;
                state_d    = T5;
            end
            T5: begin
                if (is_md) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    state_d     = T6;
                end else begin
                    if (is_alu) begin
                        bus.Zlowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.Rin     = 1'b1;
                    end
                    state_d = T0;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = T0;
            end
            HALT:    state_d = HALT;
            default: state_d = RESET_S;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle control vectors checked against hand-built tables.
`timescale 1ns/1ps
module tb_control_unit;

    logic Clock = 1'b0;
    logic clear;
    int   n_cmp = 0;
    int   n_mis = 0;

    control_unit_if cu ();

    control_unit dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (cu)
    );

    always #5 Clock = ~Clock;

    localparam logic [21:0] RUN      = 22'd1;
    localparam logic [21:0] ROUT     = 22'd1 << 1;
    localparam logic [21:0] RIN      = 22'd1 << 2;
    localparam logic [21:0] GRC      = 22'd1 << 3;
    localparam logic [21:0] GRB      = 22'd1 << 4;
    localparam logic [21:0] GRA      = 22'd1 << 5;
    localparam logic [21:0] READ     = 22'd1 << 6;
    localparam logic [21:0] INCPC    = 22'd1 << 7;
    localparam logic [21:0] LOIN     = 22'd1 << 8;
    localparam logic [21:0] HIIN     = 22'd1 << 9;
    localparam logic [21:0] YIN      = 22'd1 << 10;
    localparam logic [21:0] IRIN     = 22'd1 << 11;
    localparam logic [21:0] MDRIN    = 22'd1 << 12;
    localparam logic [21:0] PCIN     = 22'd1 << 13;
    localparam logic [21:0] ZIN      = 22'd1 << 14;
    localparam logic [21:0] MARIN    = 22'd1 << 15;
    localparam logic [21:0] LOOUT    = 22'd1 << 16;
    localparam logic [21:0] HIOUT    = 22'd1 << 17;
    localparam logic [21:0] MDROUT   = 22'd1 << 18;
    localparam logic [21:0] ZLOWOUT  = 22'd1 << 19;
    localparam logic [21:0] ZHIGHOUT = 22'd1 << 20;
    localparam logic [21:0] PCOUT    = 22'd1 << 21;

    localparam logic [21:0] S_OFF = '0;
    localparam logic [21:0] S_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [21:0] S_T1F = ZLOWOUT | PCIN | READ | MDRIN | RUN;
    localparam logic [21:0] S_T1W = READ | MDRIN | RUN;
    localparam logic [21:0] S_T2  = MDROUT | IRIN | RUN;
    localparam logic [21:0] S_T3A = GRB | ROUT | YIN | RUN;
    localparam logic [21:0] S_T3N = RUN;
    localparam logic [21:0] S_T4  = GRC | ROUT | ZIN | RUN;
    localparam logic [21:0] S_T5A = ZLOWOUT | GRA | RIN | RUN;
    localparam logic [21:0] S_T5M = ZLOWOUT | LOIN | RUN;
    localparam logic [21:0] S_T6  = ZHIGHOUT | HIIN | RUN;
    localparam logic [21:0] BUSSRC = PCOUT | ZHIGHOUT | ZLOWOUT | MDROUT | HIOUT | LOOUT | ROUT;

    logic [21:0] obs;
    assign obs = {cu.PCout, cu.Zhighout, cu.Zlowout, cu.MDRout, cu.HIout, cu.LOout,
                  cu.MARin, cu.Zin, cu.PCin, cu.MDRin, cu.IRin, cu.Yin, cu.HIin, cu.LOin,
                  cu.IncPC, cu.Read, cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.Run};

    // Bus exclusivity is checked on every cycle once reset has been applied
    logic bus_chk_en = 1'b0;
    always @(negedge Clock) begin
        if (bus_chk_en) begin
            n_cmp++;
            if ($countones(obs & BUSSRC) > 1) begin
                n_mis++;
                $display("FAIL bus_exclusive t=%0t: sources=%h, required at most one bit set", $time, obs & BUSSRC);
            end
        end
    end

    task automatic test_reset();
        clear        = 1'b1;
        cu.IR        = 32'h2891_8000;
        cu.Mem_ready = 1'b1;
        @(negedge Clock);
        bus_chk_en = 1'b1;
        n_cmp++;
        if (obs !== S_OFF || cu.opcode !== 5'b00000) begin
            n_mis++;
            $display("FAIL reset_state: ctl=%h op=%b required ctl=%h op=00000", obs, cu.opcode, S_OFF);
        end
        clear = 1'b0;
        @(negedge Clock);
        n_cmp++;
        if (obs !== S_T0 || cu.opcode !== 5'b00011) begin
            n_mis++;
            $display("FAIL reset_to_t0: ctl=%h op=%b required ctl=%h op=00011", obs, cu.opcode, S_T0);
        end
    endtask

    task automatic test_alu_and();
        logic [21:0] ev [6] = '{S_T1F, S_T2, S_T3A, S_T4, S_T5A, S_T0};
        logic [4:0]  eo [6] = '{5'b0, 5'b0, 5'b0, 5'b00101, 5'b0, 5'b00011};
        cu.IR = 32'h2891_8000;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== ev[i] || cu.opcode !== eo[i]) begin
                n_mis++;
                $display("FAIL alu_and step %0d: ctl=%h op=%b required ctl=%h op=%b", i, obs, cu.opcode, ev[i], eo[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [21:0] ev [7] = '{S_T1F, S_T2, S_T3A, S_T4, S_T5M, S_T6, S_T0};
        logic [4:0]  eo [7] = '{5'b0, 5'b0, 5'b0, 5'b10000, 5'b0, 5'b0, 5'b00011};
        cu.IR = 32'h8033_8000;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== ev[i] || cu.opcode !== eo[i]) begin
                n_mis++;
                $display("FAIL div step %0d: ctl=%h op=%b required ctl=%h op=%b", i, obs, cu.opcode, ev[i], eo[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [21:0] ev [9] = '{S_T1F, S_T1W, S_T1W, S_T1W, S_T2, S_T3A, S_T4, S_T5A, S_T0};
        logic [4:0]  eo [9] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00011, 5'b0, 5'b00011};
        logic        mr [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        cu.IR        = 32'h1891_8000;
        cu.Mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== ev[i] || cu.opcode !== eo[i]) begin
                n_mis++;
                $display("FAIL mem_wait step %0d: ctl=%h op=%b required ctl=%h op=%b", i, obs, cu.opcode, ev[i], eo[i]);
            end
            cu.Mem_ready = mr[i];
        end
    endtask

    task automatic test_nop();
        logic [21:0] ev [4] = '{S_T1F, S_T2, S_T3N, S_T0};
        logic [4:0]  eo [4] = '{5'b0, 5'b0, 5'b0, 5'b00011};
        logic [31:0] irs [2] = '{32'hD000_0000, 32'hF800_0000};
        for (int k = 0; k < 2; k++) begin
            cu.IR = irs[k];
            for (int i = 0; i < 4; i++) begin
                @(negedge Clock);
                n_cmp++;
                if (obs !== ev[i] || cu.opcode !== eo[i]) begin
                    n_mis++;
                    $display("FAIL nop ir=%h step %0d: ctl=%h op=%b required ctl=%h op=%b", irs[k], i, obs, cu.opcode, ev[i], eo[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [21:0] ev [3] = '{S_T1F, S_T2, S_T3N};
        cu.IR = 32'hD800_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== ev[i] || cu.opcode !== 5'b00000) begin
                n_mis++;
                $display("FAIL halt_fetch step %0d: ctl=%h op=%b required ctl=%h op=00000", i, obs, cu.opcode, ev[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== S_OFF || cu.opcode !== 5'b00000) begin
                n_mis++;
                $display("FAIL halt_hold cycle %0d: ctl=%h op=%b required ctl=%h op=00000", i, obs, cu.opcode, S_OFF);
            end
        end
        clear = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if (obs !== S_OFF || cu.opcode !== 5'b00000) begin
            n_mis++;
            $display("FAIL halt_clear: ctl=%h op=%b required ctl=%h op=00000", obs, cu.opcode, S_OFF);
        end
        clear = 1'b0;
        cu.IR = 32'h2891_8000;
        @(negedge Clock);
        n_cmp++;
        if (obs !== S_T0 || cu.opcode !== 5'b00011) begin
            n_mis++;
            $display("FAIL halt_restart: ctl=%h op=%b required ctl=%h op=00011", obs, cu.opcode, S_T0);
        end
    endtask

    task automatic test_clear_mid();
        logic [21:0] ev [4] = '{S_T1F, S_T2, S_T3A, S_T4};
        logic [4:0]  eo [4] = '{5'b0, 5'b0, 5'b0, 5'b00011};
        cu.IR = 32'h1891_8000;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            n_cmp++;
            if (obs !== ev[i] || cu.opcode !== eo[i]) begin
                n_mis++;
                $display("FAIL clear_mid step %0d: ctl=%h op=%b required ctl=%h op=%b", i, obs, cu.opcode, ev[i], eo[i]);
            end
        end
        clear = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if (obs !== S_OFF || cu.opcode !== 5'b00000) begin
            n_mis++;
            $display("FAIL clear_mid_abort: ctl=%h op=%b required ctl=%h op=00000", obs, cu.opcode, S_OFF);
        end
        clear = 1'b0;
        @(negedge Clock);
        n_cmp++;
        if (obs !== S_T0 || cu.opcode !== 5'b00011) begin
            n_mis++;
            $display("FAIL clear_mid_restart: ctl=%h op=%b required ctl=%h op=00011", obs, cu.opcode, S_T0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_and();
        test_div();
        test_mem_wait();
        test_nop();
        test_halt();
        test_clear_mid();
        @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
